// File: rtl/hall_emulator_if.sv
// Control and sensor bundle of the hall emulator; master drives the rotor
// controls, slave (the emulator) drives the sensor lines and status.
interface hall_emulator_if #(
  parameter int unsigned PERIOD_W = 24
);
  logic                enable;
  logic [PERIOD_W-1:0] period;
  logic                period_valid;
  logic                hall_1;
  logic                hall_2;
  logic [15:0]         rev_cnt;
  logic                running;

  modport master (
    output enable, period, period_valid,
    input  hall_1, hall_2, rev_cnt, running
  );

  modport slave (
    input  enable, period, period_valid,
    output hall_1, hall_2, rev_cnt, running
  );
endinterface

// File: rtl/hall_emulator.sv
// Two-sensor hall emulator: hall_1 pulses at angle 0, hall_2 at angle 180 of a rotor
// spinning at a programmable period. Define HALL_EMULATOR_JITTER_EN for per-revolution jitter.
module hall_emulator #(
  parameter int unsigned PULSE_WIDTH = 64,
  parameter int unsigned PERIOD_W    = 24,
  parameter int unsigned MIN_PERIOD  = 4 * PULSE_WIDTH
) (
  input logic            clk,
  input logic            rst,
  hall_emulator_if.slave bus
);
  localparam int unsigned         PULSE_CW = $clog2(PULSE_WIDTH + 1);
  localparam logic [PERIOD_W-1:0] MIN_P    = PERIOD_W'(MIN_PERIOD);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] HALF_A = 2'd1;
  localparam logic [1:0] HALF_B = 2'd2;

  logic [1:0]          state_q, state_d;
  logic [PERIOD_W-1:0] phase_q, phase_d;
  logic [PERIOD_W-1:0] active_q, active_d;
  logic [PERIOD_W-1:0] pending_q, pending_d;
  logic [PULSE_CW-1:0] pulse_q, pulse_d;
  logic                hall_1_q, hall_1_d;
  logic                hall_2_q, hall_2_d;
  logic                running_q, running_d;
  logic [15:0]         rev_q, rev_d;

  logic [PERIOD_W-1:0] half_nom;
  logic [PERIOD_W-1:0] half_len;
  logic                half_done;

  // HALF_A takes the floor and HALF_B the ceiling, so odd periods still sum exactly.
  assign half_nom = (state_q == HALF_B) ? (active_q - (active_q >> 1)) : (active_q >> 1);

`ifdef HALL_EMULATOR_JITTER_EN
  localparam int unsigned JW = PERIOD_W + 2;

  logic [15:0]          lfsr_q;
  logic signed [JW-1:0] jit_len;
  logic signed [JW-1:0] jit_floor;

  assign jit_floor = $signed(JW'(PULSE_WIDTH + 1));
  assign jit_len   = $signed({2'b00, half_nom}) + $signed(JW'(lfsr_q[3:0])) - $signed(JW'(8));
  assign half_len  = (jit_len < jit_floor) ? PERIOD_W'(jit_floor) : PERIOD_W'(jit_len);

  // Fibonacci LFSR, taps 16,15,13,4, stepped once per completed revolution.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= 16'hACE1;
    end else if (bus.enable && (state_q == HALF_B) && half_done) begin
      lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[14] ^ lfsr_q[12] ^ lfsr_q[3]};
    end
  end
`else
  assign half_len = half_nom;
`endif

  assign half_done = (phase_q == (half_len - 1'b1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      phase_q   <= '0;
      active_q  <= '0;
      pending_q <= '0;
      pulse_q   <= '0;
      hall_1_q  <= 1'b1;
      hall_2_q  <= 1'b1;
      running_q <= 1'b0;
      rev_q     <= '0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      pulse_q   <= pulse_d;
      hall_1_q  <= hall_1_d;
      hall_2_q  <= hall_2_d;
      running_q <= running_d;
      rev_q     <= rev_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    active_d  = active_q;
    pending_d = pending_q;
    pulse_d   = pulse_q;
    hall_1_d  = hall_1_q;
    hall_2_d  = hall_2_q;
    rev_d     = rev_q;

    if (bus.period_valid) begin
      pending_d = (bus.period >= MIN_P) ? bus.period : MIN_P;
    end

    // A pulse starts on the first phase cycle of each half and runs PULSE_WIDTH cycles.
    if ((state_q != IDLE) && (phase_q == '0)) begin
      if (state_q == HALF_A) hall_1_d = 1'b0;
      else                   hall_2_d = 1'b0;
      pulse_d = PULSE_CW'(PULSE_WIDTH - 1);
    end else if (!hall_1_q || !hall_2_q) begin
      if (pulse_q == '0) begin
        hall_1_d = 1'b1;
        hall_2_d = 1'b1;
      end else begin
        pulse_d = pulse_q - 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (bus.enable && (pending_q != '0)) begin
          state_d  = HALF_A;
          active_d = pending_q;
          phase_d  = '0;
        end
      end
      HALF_A: begin
        if (half_done) begin
          state_d = HALF_B;
          phase_d = '0;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      HALF_B: begin
        if (half_done) begin
          state_d  = HALF_A;
          phase_d  = '0;
          active_d = pending_q;
          rev_d    = rev_q + 16'd1;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Disable stops the rotor at once and aborts any pulse; rev_cnt is kept.
    if (!bus.enable) begin
      state_d  = IDLE;
      phase_d  = '0;
      pulse_d  = '0;
      hall_1_d = 1'b1;
      hall_2_d = 1'b1;
      rev_d    = rev_q;
    end

    running_d = (state_d != IDLE);
  end

  assign bus.hall_1  = hall_1_q;
  assign bus.hall_2  = hall_2_q;
  assign bus.rev_cnt = rev_q;
  assign bus.running = running_q;
endmodule
